// File: rtl/co_rmw_seq.sv
// co_rmw_seq: read-modify-write bus sequencer for memory-operand INC, DEC,
// ASL, LSR, ROL and ROR. It runs read / modify / write / done cycles on the
// external bus. In the modify cycle it drives the combinational co_alu, then
// it returns the written value and the updated N, Z and C flags.
//
// Optional feature macro: RMW_DUMMY_WRITE_EN
//   defined   : MODIFY writes the unmodified operand back (NMOS behaviour).
//   undefined : MODIFY is a read cycle of the same address; its data is ignored.
//
// Ports
//   I_clock, I_reset_n          clock, synchronous active-low reset
//   I_start, I_op, I_addr       request, operation (0..5, 6/7 reserved), address
//   I_carry                     C flag at request time
//   I_rdy, I_rdata              bus ready (stalls reads only), read data
//   O_addr, O_rw, O_wdata       bus address, 1=read/0=write, write data
//   O_alu_control/lhs/carry     ALU operation, operand and carry in
//   I_alu_result/carry/sign/zero ALU outputs
//   O_busy, O_done              busy in READ..WRITE, one-cycle completion strobe
//   O_result, O_carry/sign/zero written value and flags, held until next done

package co_pkg;
  typedef enum logic [2:0] {
    control_nop, control_inc, control_dec, control_asl,
    control_lsr, control_rol, control_ror
  } control_type;
endpackage

module co_rmw_seq
  import co_pkg::*;
(
  input  logic              I_clock,
  input  logic              I_reset_n,
  input  logic              I_start,
  input  logic [2:0]        I_op,
  input  logic [15:0]       I_addr,
  input  logic              I_carry,
  input  logic              I_rdy,
  input  logic [7:0]        I_rdata,
  output logic [15:0]       O_addr,
  output logic              O_rw,
  output logic [7:0]        O_wdata,
  output control_type       O_alu_control,
  output logic [7:0]        O_alu_lhs,
  output logic              O_alu_carry,
  input  logic [7:0]        I_alu_result,
  input  logic              I_alu_carry,
  input  logic              I_alu_sign,
  input  logic              I_alu_zero,
  output logic              O_busy,
  output logic              O_done,
  output logic [7:0]        O_result,
  output logic              O_carry,
  output logic              O_sign,
  output logic              O_zero
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_MODIFY, S_WRITE, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [2:0]  op_q, op_d;
  logic        cin_q, cin_d;
  logic [7:0]  opnd_q, opnd_d;
  // Modify-step results, kept separate from the visible outputs so those
  // stay stable until the completion strobe.
  logic [7:0]  res_q, res_d;
  logic        nc_q, nc_d, nn_q, nn_d, nz_q, nz_d;
  logic [7:0]  result_q, result_d;
  logic        carry_q, carry_d, sign_q, sign_d, zero_q, zero_d;

  always_ff @(posedge I_clock) begin
    if (!I_reset_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      op_q     <= '0;
      cin_q    <= 1'b0;
      opnd_q   <= '0;
      res_q    <= '0;
      nc_q     <= 1'b0;
      nn_q     <= 1'b0;
      nz_q     <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      op_q     <= op_d;
      cin_q    <= cin_d;
      opnd_q   <= opnd_d;
      res_q    <= res_d;
      nc_q     <= nc_d;
      nn_q     <= nn_d;
      nz_q     <= nz_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      sign_q   <= sign_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    op_d     = op_q;
    cin_d    = cin_q;
    opnd_d   = opnd_q;
    res_d    = res_q;
    nc_d     = nc_q;
    nn_d     = nn_q;
    nz_d     = nz_q;
    result_d = result_q;
    carry_d  = carry_q;
    sign_d   = sign_q;
    zero_d   = zero_q;

    O_addr        = addr_q;
    O_rw          = 1'b1;
    O_wdata       = '0;
    O_alu_control = control_nop;
    O_alu_lhs     = '0;
    O_alu_carry   = 1'b0;
    O_busy        = 1'b0;
    O_done        = 1'b0;

    // A new request is accepted only when not busy.
    if ((state_q == S_IDLE || state_q == S_DONE) && I_start) begin
      addr_d = I_addr;
      op_d   = I_op;
      cin_d  = I_carry;
    end

    case (state_q)
      S_IDLE: if (I_start) state_d = S_READ;
      S_READ: begin
        O_busy = 1'b1;
        if (I_rdy) begin
          opnd_d  = I_rdata;
          state_d = S_MODIFY;
        end
      end
      S_MODIFY: begin
        O_busy    = 1'b1;
`ifdef RMW_DUMMY_WRITE_EN
        O_rw      = 1'b0;
        O_wdata   = opnd_q;
`endif
        O_alu_lhs = opnd_q;
        res_d     = I_alu_result;
        nn_d      = I_alu_sign;
        nz_d      = I_alu_zero;
        nc_d      = I_alu_carry;
        case (op_q)
          3'd0: begin O_alu_control = control_inc; nc_d = cin_q; end
          3'd1: begin O_alu_control = control_dec; nc_d = cin_q; end
          3'd2: O_alu_control = control_asl;
          3'd3: O_alu_control = control_lsr;
          3'd4: begin O_alu_control = control_rol; O_alu_carry = cin_q; end
          3'd5: begin O_alu_control = control_ror; O_alu_carry = cin_q; end
          default: begin
            // Reserved: write the operand back, leave every flag untouched.
            res_d = opnd_q;
            nc_d  = cin_q;
            nn_d  = sign_q;
            nz_d  = zero_q;
          end
        endcase
        state_d = S_WRITE;
      end
      S_WRITE: begin
        O_busy   = 1'b1;
        O_rw     = 1'b0;
        O_wdata  = res_q;
        result_d = res_q;
        carry_d  = nc_q;
        sign_d   = nn_q;
        zero_d   = nz_q;
        state_d  = S_DONE;
      end
      S_DONE: begin
        O_done  = 1'b1;
        state_d = I_start ? S_READ : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign O_result = result_q;
  assign O_carry  = carry_q;
  assign O_sign   = sign_q;
  assign O_zero   = zero_q;

endmodule

// File: doc/co_rmw_seq.md
# co_rmw_seq

Read-modify-write sequencer for the 2A03 core: it runs the bus cycles of memory-operand INC, DEC, ASL, LSR, ROL and ROR instructions and drives the combinational `co_alu` for the modify step. The control unit hands it an effective address and an operation. It performs the 6502 read / dummy-write / write sequence and returns the written value and the updated N, Z and C flags. It sits between the instruction sequencer, the external bus interface and the ALU.

## Interface
- No parameters.
- `I_clock  in  1`  core clock.
- `I_reset_n  in  1`  synchronous, active-low reset.
- `I_start  in  1`  request a RMW operation; sampled only in IDLE or DONE.
- `I_op  in  3`  operation: 0 INC, 1 DEC, 2 ASL, 3 LSR, 4 ROL, 5 ROR; 6 and 7 are reserved.
- `I_addr  in  16`  effective address; latched with I_start.
- `I_carry  in  1`  current C flag; latched with I_start.
- `I_rdy  in  1`  bus ready; low stalls read cycles only.
- `I_rdata  in  8`  bus read data.
- `O_addr  out  16`  bus address.
- `O_rw  out  1`  1 = read, 0 = write.
- `O_wdata  out  8`  bus write data.
- `O_alu_control  out  control_type`  ALU operation.
- `O_alu_lhs  out  8`  ALU left operand.
- `O_alu_carry  out  1`  ALU carry in.
- `I_alu_result  in  8`, `I_alu_carry  in  1`, `I_alu_sign  in  1`, `I_alu_zero  in  1`  ALU outputs.
- `O_busy  out  1`  high in READ, MODIFY and WRITE.
- `O_done  out  1`  one-cycle completion strobe.
- `O_result  out  8`  value written back; valid with O_done and held until the next completion.
- `O_carry`, `O_sign`, `O_zero`  `out  1`  updated flags; valid with O_done and held until the next completion.

## Operation
- States and transitions:
  - IDLE: I_start → READ.
  - READ: I_rdy=1 → MODIFY; I_rdy=0 → stay in READ.
  - MODIFY → WRITE.
  - WRITE → DONE.
  - DONE: I_start → READ; otherwise → IDLE.
- READ
  - O_addr = latched address, O_rw = 1.
  - On an edge with I_rdy=1, I_rdata is captured into the operand register.
- MODIFY
  - O_rw = 0, O_wdata = operand (the NMOS dummy write).
  - O_alu_lhs = operand; O_alu_control is mapped from I_op (inc, dec, asl, lsr, rol, ror).
  - The ALU result and flags are captured at the end of the cycle.
- Carry in and carry out by operation:
  - INC and DEC: O_alu_carry = 0, because the ALU adds carry-in on inc and dec. The resulting C equals the latched I_carry, unchanged.
  - ROL and ROR: O_alu_carry = latched I_carry. The resulting C comes from I_alu_carry.
  - ASL and LSR: the resulting C comes from I_alu_carry.
- N and Z are always taken from I_alu_sign and I_alu_zero.
- Reserved ops (6, 7): O_alu_control = control_nop. The operand is written back unchanged and C, N, Z are all held at their pre-operation values (latched I_carry for C).
- WRITE: O_rw = 0, O_wdata = captured result, O_addr held.
- DONE: O_done = 1, O_busy = 0; the bus returns to read (O_rw = 1).
- O_alu_control = control_nop in every state other than MODIFY.
- I_start while O_busy = 1 is ignored; no queueing.
- I_rdy is ignored in MODIFY and WRITE; writes never stall.
- Address arithmetic: none; all cycles use the latched 16-bit address.

## Timing
- Reset values: state IDLE, O_busy 0, O_done 0, O_rw 1, O_addr 0, O_wdata 0, O_alu_control control_nop, O_alu_lhs 0, O_alu_carry 0, O_result 0, O_carry 0, O_sign 0, O_zero 0.
- Latency, with I_start sampled at edge 0 and I_rdy=1:
  - cycle 1 READ, cycle 2 MODIFY, cycle 3 WRITE, cycle 4 DONE.
  - Each cycle I_rdy is low in READ adds one cycle.
- Back-to-back: I_start sampled in DONE gives READ in the next cycle, so the throughput is 4 cycles per operation.
- Reset mid-operation: IDLE in the cycle after the reset edge. No further write cycle is issued and O_done is not pulsed. A write already issued is not undone.

## Configuration
- `RMW_DUMMY_WRITE_EN` defined: MODIFY is a write cycle of the unmodified operand (NMOS 2A03 behaviour).
- `RMW_DUMMY_WRITE_EN` undefined: MODIFY is a read cycle (O_rw = 1, O_addr held).
  - Read data is ignored and I_rdy is still ignored.
  - Latency and flag behaviour are unchanged.

## Test plan
- INC at 0x0010, memory 0xFF, I_carry=1:
  - bus: read 0x0010, write 0xFF, write 0x00.
  - O_done at cycle 4 with O_result 0x00, Z=1, N=0, C=1.
- ROR at 0x4016, memory 0x01, I_carry=1: writes 0x01 then 0x80; O_result 0x80, C=1, N=1, Z=0.
- ASL at 0x0200, memory 0xC0, with I_rdy low for the first 2 READ cycles:
  - READ lasts 3 cycles and O_done lands at cycle 6.
  - Final write 0x80, C=1, N=1.
- I_start pulsed during MODIFY: ignored. I_start asserted in DONE: READ in the next cycle, with the new address latched.
- I_reset_n low during MODIFY: in the next cycle O_rw=1, O_busy=0, no write of the result, O_done stays 0.
- With `RMW_DUMMY_WRITE_EN` undefined, DEC at 0x0300, memory 0x00:
  - cycle 2 is a read of 0x0300.
  - cycle 3 writes 0xFF; N=1, C unchanged.
